// File: rtl/eos_sched.sv
// Egress output scheduler: three class FIFOs, strict-priority issue to EBM, BE byte token bucket.
// Optional completion watchdog enabled by defining EOS_WATCHDOG_EN.
module eos_sched #(
  parameter int DEPTH       = 16,
  parameter int RATE_BYTES  = 2,
  parameter int BUCKET_MAX  = 4096,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [20:0] in_eos_md,
  input  logic        in_eos_md_wr,
  input  logic        in_eos_done,
  output logic [7:0]  out_eos_md,
  output logic        out_eos_md_wr,
  output logic        out_eos_bandwidth_discard,
  output logic [2:0]  out_eos_full,
  output logic [15:0] out_eos_drop_cnt,
  output logic        out_eos_timeout
);

  localparam int          AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] RATE_W = 32'(RATE_BYTES);
  localparam logic [31:0] MAX_W  = 32'(BUCKET_MAX);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic [18:0]   r_mem    [3][DEPTH];
  logic [AW-1:0] r_rd_ptr [3];
  logic [AW-1:0] r_wr_ptr [3];
  logic [AW:0]   r_cnt    [3];
  logic [15:0]   r_tokens;
  logic [15:0]   r_drop_cnt;
  logic [7:0]    r_out_md;
  logic          r_out_wr;
  logic          r_discard;
  logic          r_timeout;

  logic [2:0]    w_ne, w_full, w_push, w_pop;
  logic [1:0]    w_cls, w_sel;
  logic          w_pop_en, w_drop, w_be_ok, w_wdog_exp;
  logic [18:0]   w_head;
  logic [15:0]   w_len, w_tok_nxt;

  function automatic logic [15:0] bucket_clip(input logic [31:0] v);
    return (v > MAX_W) ? MAX_W[15:0] : v[15:0];
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    w_ne   = '0;
    w_full = '0;
    w_push = '0;
    for (int c = 0; c < 3; c++) begin
      w_ne[c]   = (r_cnt[c] != '0);
      w_full[c] = (r_cnt[c] == (AW+1)'(DEPTH));
    end
    w_sel    = w_ne[0] ? 2'd0 : (w_ne[1] ? 2'd1 : 2'd2);
    w_pop_en = (r_state == S_IDLE) && (|w_ne);
    w_pop    = w_pop_en ? (3'b001 << w_sel) : 3'b000;
    w_cls    = in_eos_md[20:19];
    // A full FIFO still accepts a write when its head leaves on the same edge.
    for (int c = 0; c < 3; c++)
      w_push[c] = in_eos_md_wr && (w_cls == 2'(c)) && (!w_full[c] || w_pop[c]);
    w_drop   = in_eos_md_wr && ~|w_push;
    w_head   = r_mem[w_sel][r_rd_ptr[w_sel]];
    w_len    = (w_head[18:8] == 11'd0) ? 16'd1 : {5'd0, w_head[18:8]};
    w_be_ok  = (r_tokens >= w_len);
    if (w_pop[2] && w_be_ok)
      w_tok_nxt = bucket_clip({16'd0, r_tokens - w_len} + RATE_W);
    else
      w_tok_nxt = bucket_clip({16'd0, r_tokens} + RATE_W);
  end

`ifdef EOS_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] r_wdog;

  assign w_wdog_exp = (r_state == S_WAIT) && !in_eos_done && (r_wdog == WD_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_wdog <= '0;
    else if (w_pop_en)           r_wdog <= '0;
    else if (r_state == S_WAIT)  r_wdog <= r_wdog + WD_W'(1);
  end
`else
  assign w_wdog_exp = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_pop_en) w_state_nxt = S_WAIT;
      S_WAIT:  if (in_eos_done || r_timeout) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Issue stage: pop, policing and output registers all update on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_tokens   <= MAX_W[15:0];
      r_drop_cnt <= '0;
      r_out_md   <= '0;
      r_out_wr   <= 1'b0;
      r_discard  <= 1'b0;
      r_timeout  <= 1'b0;
      for (int c = 0; c < 3; c++) begin
        r_rd_ptr[c] <= '0;
        r_wr_ptr[c] <= '0;
        r_cnt[c]    <= '0;
      end
    end else begin
      r_state   <= w_state_nxt;
      r_tokens  <= w_tok_nxt;
      r_out_wr  <= w_pop_en;
      r_discard <= w_pop[2] && !w_be_ok;
      r_timeout <= w_wdog_exp;
      if (w_pop_en) r_out_md <= w_head[7:0];
      if (w_drop)   r_drop_cnt <= sat_inc16(r_drop_cnt);
      for (int c = 0; c < 3; c++) begin
        if (w_push[c]) r_wr_ptr[c] <= r_wr_ptr[c] + AW'(1);
        if (w_pop[c])  r_rd_ptr[c] <= r_rd_ptr[c] + AW'(1);
        case ({w_push[c], w_pop[c]})
          2'b10:   r_cnt[c] <= r_cnt[c] + (AW+1)'(1);
          2'b01:   r_cnt[c] <= r_cnt[c] - (AW+1)'(1);
          default: r_cnt[c] <= r_cnt[c];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < 3; c++)
      if (w_push[c]) r_mem[c][r_wr_ptr[c]] <= in_eos_md[18:0];
  end

  assign out_eos_md                = r_out_md;
  assign out_eos_md_wr             = r_out_wr;
  assign out_eos_bandwidth_discard = r_discard;
  assign out_eos_full              = w_full;
  assign out_eos_drop_cnt          = r_drop_cnt;
  assign out_eos_timeout           = r_timeout;

endmodule
